// File: rtl/mips_harvard_instr_responder_pkg.sv
// rtl/mips_harvard_instr_responder_pkg.sv - shared constants, state codes and fetch decode for the instruction responder
package mips_harvard_instr_responder_pkg;

  localparam logic [31:0] RESET_VECTOR    = 32'hBFC00000;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
  localparam logic [31:0] FETCH_COUNT_MAX = 32'hFFFF_FFFF;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  typedef struct packed {
    logic        legal;
    logic [29:0] idx;
  } fetch_decode_t;

  // Word index is taken from the wrapped byte offset; legality needs word
  // alignment, an address at or above the base, and an index inside the array.
  function automatic fetch_decode_t decode_fetch(input logic [31:0] addr,
                                                 input logic [31:0] base,
                                                 input logic [31:0] depth);
    fetch_decode_t d;
    logic [31:0]   off;
    off     = addr - base;
    d.idx   = off[31:2];
    d.legal = (addr[1:0] == 2'b00) && (addr >= base) && ({2'b00, off[31:2]} < depth);
    return d;
  endfunction

endpackage

// File: rtl/instr_word_ram.sv
// rtl/instr_word_ram.sv - instruction word store, one synchronous write port and one asynchronous read port
module instr_word_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents survive reset; the owner hides stale words with its loaded count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_harvard_instr_responder.sv
// rtl/mips_harvard_instr_responder.sv - program loader, CPU bring-up sequencer and fetch responder for mips_cpu_harvard
module mips_harvard_instr_responder
  import mips_harvard_instr_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          DEPTH_WORDS = 256,
  parameter int          HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  output logic        cpu_reset,
  output logic        cpu_clk_enable,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int LW = AW + 1;

  logic [1:0]    state;
  logic [AW-1:0] wptr;
  logic [LW-1:0] loaded;
  logic [31:0]   hold_cnt;

  fetch_decode_t dec;
  logic          in_loaded;
  logic          transfer;
  logic [31:0]   ram_rdata;

  assign dec       = decode_fetch(instr_address, BASE_ADDR, 32'(DEPTH_WORDS));
  assign in_loaded = ({2'b00, dec.idx} < {{(32-LW){1'b0}}, loaded});
  assign transfer  = load_valid && load_ready;

  assign load_ready     = (state == ST_LOAD);
  assign cpu_reset      = (state == ST_LOAD) || (state == ST_HOLD);
  assign cpu_clk_enable = (state == ST_HOLD) || (state == ST_RUN);

  // Words beyond the loaded count read as NOP so stale contents never leak.
  assign instr_readdata = (dec.legal && in_loaded) ? ram_rdata : NOP_INSTR;

  instr_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .we    (transfer && !reset),
    .waddr (wptr),
    .wdata (load_data),
    .raddr (dec.idx[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Bring-up sequencer: load program, hold CPU in reset, run, halt on bad fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_LOAD;
      wptr        <= '0;
      loaded      <= '0;
      hold_cnt    <= '0;
      fault       <= 1'b0;
      fault_addr  <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (transfer) begin
            wptr   <= wptr + AW'(1);
            loaded <= loaded + LW'(1);
            if (load_last || (wptr == AW'(DEPTH_WORDS - 1))) begin
              state    <= ST_HOLD;
              hold_cnt <= '0;
            end
          end
        end
        ST_HOLD: begin
          if (hold_cnt == 32'(HOLD_CYCLES - 1)) begin
            state <= ST_RUN;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end
        ST_RUN: begin
          if (!dec.legal) begin
            fault      <= 1'b1;
            fault_addr <= instr_address;
            state      <= ST_HALT;
          end else if (fetch_count != FETCH_COUNT_MAX) begin
            fetch_count <= fetch_count + 32'd1;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_harvard_instr_responder.sv
// tb/tb_mips_harvard_instr_responder.sv - self-checking bench for mips_harvard_instr_responder
module tb_mips_harvard_instr_responder;

  localparam int          DEPTH = 256;
  localparam int          HOLD  = 2;
  localparam logic [31:0] BASE  = 32'hBFC00000;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        cpu_reset;
  logic        cpu_clk_enable;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  logic        s_reset;
  logic        s_load_valid;
  logic        s_load_ready;
  logic [31:0] s_load_data;
  logic        s_load_last;
  logic [31:0] s_instr_address;
  logic [31:0] s_instr_readdata;
  logic        s_cpu_reset;
  logic        s_cpu_clk_enable;
  logic        s_fault;
  logic [31:0] s_fault_addr;
  logic [31:0] s_fetch_count;

  int n_assert = 0;
  int n_fail   = 0;

  mips_harvard_instr_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .cpu_reset(cpu_reset), .cpu_clk_enable(cpu_clk_enable),
    .fault(fault), .fault_addr(fault_addr), .fetch_count(fetch_count)
  );

  mips_harvard_instr_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(4), .HOLD_CYCLES(HOLD)) dut_small (
    .clk(clk), .reset(s_reset), .load_valid(s_load_valid), .load_ready(s_load_ready),
    .load_data(s_load_data), .load_last(s_load_last), .instr_address(s_instr_address),
    .instr_readdata(s_instr_readdata), .cpu_reset(s_cpu_reset), .cpu_clk_enable(s_cpu_clk_enable),
    .fault(s_fault), .fault_addr(s_fault_addr), .fetch_count(s_fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: program as a queue, phase as a plain enum.
  typedef enum {M_LOAD, M_HOLD, M_RUN, M_HALT} mphase_t;
  mphase_t     m_phase;
  logic [31:0] m_prog[$];
  int          m_hold_left;
  logic        m_fault;
  logic [31:0] m_fa;
  logic [31:0] m_fc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_legal(input logic [31:0] a);
    longint unsigned off;
    if (a % 4 != 0) return 0;
    if (a < BASE) return 0;
    off = longint'(a) - longint'(BASE);
    return (off / 4) < DEPTH;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    longint unsigned idx;
    if (!ref_legal(a)) return 32'h0;
    idx = (longint'(a) - longint'(BASE)) / 4;
    if (idx < m_prog.size()) return m_prog[idx];
    return 32'h0;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_phase = M_LOAD;
      m_prog.delete();
      m_fault = 1'b0;
      m_fa    = 32'h0;
      m_fc    = 32'h0;
      return;
    end
    case (m_phase)
      M_LOAD: if (load_valid) begin
        m_prog.push_back(load_data);
        if (load_last || m_prog.size() == DEPTH) begin
          m_phase     = M_HOLD;
          m_hold_left = HOLD;
        end
      end
      M_HOLD: begin
        m_hold_left--;
        if (m_hold_left == 0) m_phase = M_RUN;
      end
      M_RUN: begin
        if (ref_legal(instr_address)) begin
          if (m_fc != 32'hFFFF_FFFF) m_fc++;
        end else begin
          m_fault = 1'b1;
          m_fa    = instr_address;
          m_phase = M_HALT;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/load_ready"}, 32'(load_ready), 32'(m_phase == M_LOAD));
    chk({tag, "/cpu_reset"}, 32'(cpu_reset), 32'(m_phase == M_LOAD || m_phase == M_HOLD));
    chk({tag, "/clk_enable"}, 32'(cpu_clk_enable), 32'(m_phase == M_HOLD || m_phase == M_RUN));
    chk({tag, "/fault"}, 32'(fault), 32'(m_fault));
    chk({tag, "/fault_addr"}, fault_addr, m_fa);
    chk({tag, "/fetch_count"}, fetch_count, m_fc);
    chk({tag, "/readdata"}, instr_readdata, ref_read(instr_address));
  endtask

  task automatic cycle(input string tag);
    #1;
    check_all(tag);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load_valid = 1'b0;
    load_last = 1'b0;
    cycle("reset");
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w, input logic last, input string tag);
    load_valid = 1'b1;
    load_data  = w;
    load_last  = last;
    cycle(tag);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic hold_to_run();
    for (int i = 0; i < HOLD; i++) cycle("hold");
  endtask

  logic [31:0] w[3];
  logic [31:0] bad_addr[2];
  logic [31:0] nw;
  int          n;
  int          r;

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = 32'h0; load_last = 1'b0; instr_address = BASE;
    s_reset = 1'b1; s_load_valid = 1'b0; s_load_data = 32'h0; s_load_last = 1'b0; s_instr_address = BASE;
    bad_addr[0] = 32'hBFC00400;
    bad_addr[1] = 32'hBFBFFFFC;

    // 1: reset state
    #1;
    model_edge();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_all("t1");
    chk("t1 load_ready", 32'(load_ready), 32'd1);
    chk("t1 cpu_reset", 32'(cpu_reset), 32'd1);

    // 2: three words with a two-cycle stall, then HOLD and RUN
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    load_word(w[0], 1'b0, "t2 w0");
    cycle("t2 stall");
    cycle("t2 stall");
    load_word(w[1], 1'b0, "t2 w1");
    load_word(w[2], 1'b1, "t2 w2");
    instr_address = BASE + 32'd4;
    #1;
    chk("t2 hold word1", instr_readdata, w[1]);
    chk("t2 hold en", 32'(cpu_clk_enable), 32'd1);
    cycle("t2 hold0");
    instr_address = BASE + 32'hC;
    #1;
    chk("t2 unloaded nop", instr_readdata, 32'h0);
    cycle("t2 hold1");
    chk("t2 run rst", 32'(cpu_reset), 32'd0);
    chk("t2 run en", 32'(cpu_clk_enable), 32'd1);

    // 3: three legal fetches
    for (int i = 0; i < 3; i++) begin
      instr_address = BASE + 32'(4 * i);
      cycle("t3 fetch");
    end
    chk("t3 count", fetch_count, 32'd3);
    chk("t3 fault", 32'(fault), 32'd0);

    // 4: misaligned fetch faults and halts; later fetch leaves fault_addr alone
    instr_address = 32'hBFC00002;
    cycle("t4 bad");
    chk("t4 fault", 32'(fault), 32'd1);
    chk("t4 fault_addr", fault_addr, 32'hBFC00002);
    chk("t4 en", 32'(cpu_clk_enable), 32'd0);
    instr_address = 32'h0;
    cycle("t4 after");
    chk("t4 sticky addr", fault_addr, 32'hBFC00002);

    // 5: out-of-range above and below, each from a fresh run
    for (int k = 0; k < 2; k++) begin
      do_reset();
      load_word($urandom, 1'b1, "t5 load");
      hold_to_run();
      instr_address = bad_addr[k];
      #1;
      chk("t5 readdata", instr_readdata, 32'h0);
      cycle("t5 bad");
      chk("t5 fault", 32'(fault), 32'd1);
      chk("t5 fault_addr", fault_addr, bad_addr[k]);
    end

    // 6: reset during RUN hides stale words until reloaded
    do_reset();
    load_word(32'h1234_5678, 1'b1, "t6 load");
    hold_to_run();
    instr_address = BASE;
    cycle("t6 run");
    do_reset();
    #1;
    chk("t6 cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t6 stale nop", instr_readdata, 32'h0);
    nw = $urandom;
    load_word(nw, 1'b1, "t6 reload");
    hold_to_run();
    #1;
    chk("t6 new word", instr_readdata, nw);
    chk("t6 run rst", 32'(cpu_reset), 32'd0);

    // Randomized runs against the model
    for (int run = 0; run < 6; run++) begin
      do_reset();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        while ($urandom_range(0, 3) == 0) cycle("rnd stall");
        load_word($urandom, 1'b1 ? (i == n - 1) : 1'b0, "rnd load");
      end
      hold_to_run();
      for (int c = 0; c < 25; c++) begin
        r = $urandom_range(0, 19);
        case (r)
          0: instr_address = BASE + 32'(4 * $urandom_range(0, 8)) + 32'($urandom_range(1, 3));
          1: instr_address = BASE - 32'(4 * $urandom_range(1, 16));
          2: instr_address = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 16));
          3: instr_address = $urandom;
          default: instr_address = BASE + 32'(4 * $urandom_range(0, n + 3));
        endcase
        cycle("rnd fetch");
      end
    end

    // DEPTH_WORDS=4: six words with no last, only four accepted
    @(posedge clk);
    #1;
    s_reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_load_valid = 1'b1;
      s_load_data  = 32'hA0 + 32'(i);
      #1;
      chk("d4 load_ready", 32'(s_load_ready), 32'(i < 4));
      @(posedge clk);
      #1;
    end
    s_load_valid = 1'b0;
    chk("d4 ready low", 32'(s_load_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      s_instr_address = BASE + 32'(4 * i);
      #1;
      chk("d4 readback", s_instr_readdata, (i < 4) ? 32'hA0 + 32'(i) : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
